// File: rtl/lcdpll_pkg.sv
// Shared types and constants for the LCD pixel-clock PLL sequencer.
// Holds the FSM state encoding, DRP register addresses and the divider table.
package lcdpll_pkg;

  typedef enum logic [2:0] {
    ST_WR_DIV    = 3'd0,
    ST_WR_PH     = 3'd1,
    ST_HOLD_RST  = 3'd2,
    ST_WAIT_LOCK = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam logic [5:0] DRP_C1_DIV = 6'h0A;
  localparam logic [5:0] DRP_C1_PH  = 6'h0B;

  // Output divider from the 1000 MHz VCO for each pixel-clock profile.
  function automatic logic [7:0] div_of(input logic [1:0] mode);
    logic [7:0] div;
    case (mode)
      2'd0:    div = 8'd30;
      2'd1:    div = 8'd40;
      2'd2:    div = 8'd20;
      2'd3:    div = 8'd111;
      default: div = 8'd30;
    endcase
    return div;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/lcdpll_ctrl_if.sv
// PLL dynamic-configuration port bundle between the sequencer and the PLL primitive.
interface lcdpll_ctrl_if;
  logic       dcs;
  logic       dwe;
  logic [5:0] daddr;
  logic [7:0] di;

  modport master (output dcs, dwe, daddr, di);
  modport slave  (input  dcs, dwe, daddr, di);
endinterface

// File: rtl/lcdpll_lock_sync.sv
// Brings the asynchronous PLL lock into the refclk domain and qualifies it
// with a consecutive-cycle stability count.
module lcdpll_lock_sync
  import lcdpll_pkg::*;
#(
  parameter int LOCK_STABLE = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic lock_async,
  output logic lock_sync,
  output logic lock_stable
);

  // Stable is asserted in the cycle that completes the required run of highs.
  localparam logic [15:0] STAB_LIM = 16'(LOCK_STABLE - 1);

  logic        meta_r;
  logic        sync_r;
  logic [15:0] stab_r;

  // Two-flop synchronizer and consecutive-high counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      stab_r <= 16'd0;
    end else begin
      meta_r <= lock_async;
      sync_r <= meta_r;
      stab_r <= sync_r ? sat_inc(stab_r) : 16'd0;
    end
  end

  assign lock_sync   = sync_r;
  assign lock_stable = sync_r && (stab_r >= STAB_LIM);

endmodule

// File: rtl/lcdpll_ctrl.sv
// LCD clock PLL sequencer: programs the pixel-clock divider over DRP, sequences
// PLL reset and lock, and gates the downstream LCD reset on stable lock.
module lcdpll_ctrl
  import lcdpll_pkg::*;
#(
  parameter int RST_CYCLES  = 16,
  parameter int LOCK_WAIT   = 65535,
  parameter int LOCK_STABLE = 8
) (
  input  logic          refclk,
  input  logic          reset_n,
  input  logic [1:0]    mode_sel,
  input  logic          mode_req,
  input  logic          pll_lock,
  output logic          pll_reset,
  lcdpll_ctrl_if.master drp,
  output logic          lcd_rst_n,
  output logic          mode_busy,
  output logic [1:0]    cur_mode,
  output logic          cfg_err
);

  localparam logic [15:0] RST_LIM  = 16'(RST_CYCLES);
  localparam logic [15:0] WAIT_LIM = 16'(LOCK_WAIT - 1);

  state_t      state_r;
  logic        idle_r;
  logic [15:0] cnt_r;
  logic [1:0]  target_r;
  logic        lock_sync_s;
  logic        lock_ok_s;

  lcdpll_lock_sync #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_sync (
    .clk         (refclk),
    .reset_n     (reset_n),
    .lock_async  (pll_lock),
    .lock_sync   (lock_sync_s),
    .lock_stable (lock_ok_s)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge refclk) begin
    if (!reset_n) begin
      state_r   <= ST_WR_DIV;
      idle_r    <= 1'b0;
      cnt_r     <= 16'd0;
      target_r  <= 2'd0;
      pll_reset <= 1'b1;
      lcd_rst_n <= 1'b0;
      drp.dcs   <= 1'b0;
      drp.dwe   <= 1'b0;
      drp.daddr <= 6'd0;
      drp.di    <= 8'd0;
      mode_busy <= 1'b1;
      cur_mode  <= 2'd0;
      cfg_err   <= 1'b0;
    end else begin
      drp.dcs <= 1'b0;
      drp.dwe <= 1'b0;
      case (state_r)
        ST_WR_DIV: begin
          if (!idle_r) begin
            drp.dcs   <= 1'b1;
            drp.dwe   <= 1'b1;
            drp.daddr <= DRP_C1_DIV;
            drp.di    <= div_of(target_r);
            idle_r    <= 1'b1;
          end else begin
            idle_r  <= 1'b0;
            state_r <= ST_WR_PH;
          end
        end
        ST_WR_PH: begin
          if (!idle_r) begin
            drp.dcs   <= 1'b1;
            drp.dwe   <= 1'b1;
            drp.daddr <= DRP_C1_PH;
            drp.di    <= div_of(target_r) - 8'd1;
            idle_r    <= 1'b1;
          end else begin
            idle_r  <= 1'b0;
            cnt_r   <= 16'd0;
            state_r <= ST_HOLD_RST;
          end
        end
        ST_HOLD_RST: begin
          if (cnt_r >= RST_LIM) begin
            pll_reset <= 1'b0;
            cnt_r     <= 16'd0;
            state_r   <= ST_WAIT_LOCK;
          end else begin
            pll_reset <= 1'b1;
            cnt_r     <= sat_inc(cnt_r);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_ok_s) begin
            cur_mode  <= target_r;
            mode_busy <= 1'b0;
            state_r   <= ST_RUN;
          end else if (cnt_r >= WAIT_LIM) begin
            // Timeout edge is already the first cycle of the retry reset pulse.
            cfg_err   <= 1'b1;
            pll_reset <= 1'b1;
            cnt_r     <= 16'd1;
            state_r   <= ST_HOLD_RST;
          end else begin
            cnt_r <= sat_inc(cnt_r);
          end
        end
        ST_RUN: begin
          if (!lock_sync_s) begin
            lcd_rst_n <= 1'b0;
            mode_busy <= 1'b1;
            cnt_r     <= 16'd0;
            state_r   <= ST_WAIT_LOCK;
          end else if (mode_req && (mode_sel != cur_mode)) begin
            target_r  <= mode_sel;
            lcd_rst_n <= 1'b0;
            mode_busy <= 1'b1;
            pll_reset <= 1'b1;
            idle_r    <= 1'b0;
            state_r   <= ST_WR_DIV;
          end else begin
            lcd_rst_n <= 1'b1;
          end
        end
        default: begin
          idle_r    <= 1'b0;
          pll_reset <= 1'b1;
          lcd_rst_n <= 1'b0;
          mode_busy <= 1'b1;
          state_r   <= ST_WR_DIV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcdpll_ctrl.sv
// Self-checking bench for lcdpll_ctrl: randomized profile changes and lock
// timing checked against a timeline model derived from the sequencing rules.
module tb_lcdpll_ctrl;

  localparam int RST_CYCLES  = 16;
  localparam int LOCK_WAIT   = 200;
  localparam int LOCK_STABLE = 8;

  logic       refclk   = 1'b0;
  logic       reset_n  = 1'b0;
  logic [1:0] mode_sel = 2'd0;
  logic       mode_req = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic       lcd_rst_n;
  logic       mode_busy;
  logic [1:0] cur_mode;
  logic       cfg_err;

  lcdpll_ctrl_if drp ();

  lcdpll_ctrl #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_WAIT   (LOCK_WAIT),
    .LOCK_STABLE (LOCK_STABLE)
  ) dut (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .mode_sel  (mode_sel),
    .mode_req  (mode_req),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .drp       (drp),
    .lcd_rst_n (lcd_rst_n),
    .mode_busy (mode_busy),
    .cur_mode  (cur_mode),
    .cfg_err   (cfg_err)
  );

  always #10 refclk = ~refclk;

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int model_mode = 0;
  int div_tab[4] = '{30, 40, 20, 111};

  // Count every configuration write seen on the port.
  always @(posedge refclk) begin
    if (drp.dcs === 1'b1 && drp.dwe === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge refclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val(tag, 32'({pll_reset, lcd_rst_n, drp.dcs, drp.dwe, drp.daddr, drp.di,
                        mode_busy, cur_mode, cfg_err}),
              32'({1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8'h00, 1'b1, 2'b00, 1'b0}));
  endtask

  // Expects the two writes on the next cycles and returns at the pll_reset fall.
  task automatic expect_prog(input int m, input string tag);
    int k;
    step();
    check_val({tag, "_wr_div"}, 32'({drp.dcs, drp.dwe, drp.daddr, drp.di}),
              32'({1'b1, 1'b1, 6'h0A, 8'(div_tab[m])}));
    step();
    check_val({tag, "_idle1"}, 32'(drp.dcs), 32'd0);
    step();
    check_val({tag, "_wr_ph"}, 32'({drp.dcs, drp.dwe, drp.daddr, drp.di}),
              32'({1'b1, 1'b1, 6'h0B, 8'(div_tab[m] - 1)}));
    step();
    check_val({tag, "_idle2"}, 32'({drp.dcs, pll_reset}), 32'({1'b0, 1'b1}));
    k = 0;
    while (pll_reset !== 1'b0 && k < 1000) begin
      step();
      k++;
    end
    check_val({tag, "_rst_len"}, 32'(k), 32'(2 + RST_CYCLES - 1));
  endtask

  // Raises lock after a delay and checks the lcd reset release latency.
  task automatic give_lock(input int delay, input int exp_mode, input string tag);
    int k;
    int w0;
    w0 = wr_cnt;
    step(delay);
    pll_lock = 1'b1;
    k = 0;
    while (lcd_rst_n !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check_val({tag, "_lat"}, 32'(k), 32'(LOCK_STABLE + 3));
    check_val({tag, "_mode"}, 32'({cur_mode, mode_busy, pll_reset}),
              32'({2'(exp_mode), 1'b0, 1'b0}));
    check_val({tag, "_nowr"}, 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic change_mode(input int m);
    mode_sel = 2'(m);
    mode_req = 1'b1;
    pll_lock = 1'b0;
    step();
    mode_req = 1'b0;
    check_val("chg_lcd_fall", 32'({lcd_rst_n, mode_busy}), 32'({1'b0, 1'b1}));
    expect_prog(m, "chg");
    // A request while waiting for lock must be dropped.
    step(2);
    mode_sel = 2'((m + 1) % 4);
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    give_lock($urandom_range(1, 120), m, "relock");
    model_mode = m;
  endtask

  task automatic same_mode();
    int w0;
    w0 = wr_cnt;
    mode_sel = 2'(model_mode);
    mode_req = 1'b1;
    step();
    mode_req = 1'b0;
    step(20);
    check_val("same_ign", 32'({lcd_rst_n, mode_busy, cur_mode}),
              32'({1'b1, 1'b0, 2'(model_mode)}));
    check_val("same_nowr", 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic glitch();
    int k;
    int w0;
    w0 = wr_cnt;
    pll_lock = 1'b0;
    step(2);
    check_val("gl_pre", 32'(lcd_rst_n), 32'd1);
    step();
    check_val("gl_fall", 32'(lcd_rst_n), 32'd0);
    pll_lock = 1'b1;
    k = 0;
    while (lcd_rst_n !== 1'b1 && k < 100) begin
      step();
      k++;
    end
    check_val("gl_lat", 32'(k), 32'(LOCK_STABLE + 3));
    check_val("gl_state", 32'({pll_reset, cur_mode, mode_busy}),
              32'({1'b0, 2'(model_mode), 1'b0}));
    check_val("gl_nowr", 32'(wr_cnt - w0), 32'd0);
  endtask

  initial begin
    int k;
    int w0;
    reset_n = 1'b0;
    step(3);
    check_reset_vals("rst");
    reset_n = 1'b1;
    expect_prog(0, "boot");
    give_lock(100, 0, "boot_lock");
    model_mode = 0;

    change_mode(3);
    for (int i = 0; i < 6; i++) begin
      int m;
      m = int'($urandom_range(0, 3));
      if (m == model_mode) same_mode();
      else change_mode(m);
      if (i % 2 == 0) glitch();
    end
    same_mode();

    // Reset during the phase write of a profile-2 change.
    if (model_mode == 2) change_mode(1);
    mode_sel = 2'd2;
    mode_req = 1'b1;
    pll_lock = 1'b0;
    step();
    mode_req = 1'b0;
    step();
    check_val("m2_wr_div", 32'({drp.dcs, drp.daddr, drp.di}), 32'({1'b1, 6'h0A, 8'd20}));
    step();
    reset_n = 1'b0;
    step();
    check_reset_vals("midrst");
    step(2);
    check_reset_vals("midrst_hold");
    reset_n = 1'b1;
    expect_prog(0, "restart");

    // Lock never arrives: timeout and unlimited retries.
    check_val("to_err0", 32'(cfg_err), 32'd0);
    w0 = wr_cnt;
    for (int r = 0; r < 2; r++) begin
      k = 0;
      while (pll_reset !== 1'b1 && k < 1000) begin
        step();
        k++;
      end
      check_val("to_low", 32'(k), 32'(LOCK_WAIT));
      check_val("to_err", 32'(cfg_err), 32'd1);
      k = 0;
      while (pll_reset !== 1'b0 && k < 1000) begin
        step();
        k++;
      end
      check_val("to_high", 32'(k), 32'(RST_CYCLES));
    end
    check_val("to_nowr", 32'(wr_cnt - w0), 32'd0);
    check_val("to_busy", 32'({mode_busy, lcd_rst_n, cfg_err}), 32'({1'b1, 1'b0, 1'b1}));

    reset_n = 1'b0;
    step(2);
    check_reset_vals("err_clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
